intr_seq: RTL
=============

INTR_SEQ -- requirements
Module: intr_seq

Interface
REQ-001 Parameter DRAIN_CYCLES, default 3: cycles waited after fetch freeze so in-flight instructions retire (legal 1..7).
REQ-002 Parameter VEC_ADDR, default 8'h01: data-memory address holding the ISR entry vector.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 int_sig  in  1  external interrupt request.
REQ-006 rti_in  in  1  one-cycle pulse when an RTI instruction retires.
REQ-007 pc_in  in  8  current fetch PC.
REQ-008 redirect_in  in  1  taken branch/jump resolved this cycle.
REQ-009 redirect_pc_in  in  8  target of that branch/jump.
REQ-010 mem_rdata_in  in  8  data-memory port B read data (combinational read).
REQ-011 pc_write_en  out  1  0 freezes PC.
REQ-012 if_id_write_en  out  1  0 holds IF/ID.
REQ-013 flush_ifid  out  1  clears IF/ID.
REQ-014 inject_bubble  out  1  forces NOP into ID/EX.
REQ-015 memb_ovr  out  1  sequencer owns memory port B.
REQ-016 memb_addr  out  8  port B address when memb_ovr=1.
REQ-017 memb_we  out  1  port B write enable.
REQ-018 memb_wdata  out  8  port B write data.
REQ-019 sp_sel / sp_dec  out  1 / 1  address from SP (R3); decrement SP this cycle.
REQ-020 pc_ovr / pc_ovr_val  out  1 / 8  force next PC to pc_ovr_val.
REQ-021 in_isr  out  1  ISR in progress.

Function
REQ-022 FSM states IDLE, DRAIN, PUSH, VEC; encoded in a 2-bit register.
REQ-023 IDLE: all override outputs 0, pc_write_en=1, if_id_write_en=1; go to DRAIN when pending=1 and in_isr=0.
REQ-024 On IDLE->DRAIN: capture ret_pc<=pc_in; clear pending; pulse flush_ifid for that cycle.
REQ-025 DRAIN: pc_write_en=0, if_id_write_en=0, inject_bubble=1; 3-bit counter counts DRAIN_CYCLES cycles, then go to PUSH.
REQ-026 redirect_in=1 during DRAIN: ret_pc<=redirect_pc_in (last one wins); counter not restarted.
REQ-027 PUSH (1 cycle): memb_ovr=1, sp_sel=1, memb_we=1, memb_wdata=ret_pc, sp_dec=1; PC/IF/ID frozen; go to VEC.
REQ-028 VEC (1 cycle): memb_ovr=1, memb_addr=VEC_ADDR, memb_we=0, pc_ovr=1, pc_ovr_val=mem_rdata_in, pc_write_en=1; set in_isr; go to IDLE.
REQ-029 Latency: request detected at cycle N -> VEC at N+DRAIN_CYCLES+2; ISR first fetch at N+DRAIN_CYCLES+3.
REQ-030 in_isr clears on rti_in; rti_in while in_isr=0 is ignored.
REQ-031 Request while in_isr=1 or outside IDLE: held in pending, serviced after return to IDLE with in_isr=0; multiple requests collapse into one.
REQ-032 rti_in and a new request in the same cycle: in_isr clears, pending sets, DRAIN entered next cycle.
REQ-033 memb_addr and memb_wdata drive 8'h00 whenever memb_ovr=0.

Reset
REQ-034 rst=1 at any clock edge, including mid-sequence: state<=IDLE, counter<=0, pending<=0, in_isr<=0, ret_pc<=8'h00; outputs then take their IDLE values.
REQ-035 A partially completed PUSH is not rolled back; SP is owned by the register file.

Configuration
REQ-036 Macro INTR_SEQ_EDGE_EN defined: pending set on a rising edge of int_sig (registered previous sample, reset to 0).
REQ-037 Macro INTR_SEQ_EDGE_EN undefined: pending follows int_sig level, sampled only while in IDLE with in_isr=0; requests seen at any other time are not latched.

Verification
REQ-038 rst 2 cycles, pc_in=8'h20, int_sig pulse -> 3 DRAIN cycles, PUSH writes 8'h20 with sp_dec=1, VEC pc_ovr_val=M[8'h01], in_isr=1.
REQ-039 redirect_in=1, redirect_pc_in=8'h40 in the 2nd DRAIN cycle -> PUSH memb_wdata=8'h40.
REQ-040 Second int_sig edge during ISR (edge mode) -> no action until rti_in; one new sequence starts the cycle after rti_in.
REQ-041 rti_in and int_sig edge in the same cycle -> DRAIN next cycle.
REQ-042 rst asserted in PUSH -> IDLE next cycle, memb_we=0, in_isr=0, pending=0.
REQ-043 Level mode: int_sig held high during ISR -> re-entry at the first IDLE cycle after rti_in; int_sig pulsed only during DRAIN -> not latched.

Source files
------------

// File: rtl/intr_seq.sv
// Interrupt entry sequencer: freezes fetch, drains the pipe, pushes the return PC, then vectors to the ISR.
// Optional build macro INTR_SEQ_EDGE_EN selects edge-triggered requests (default: level-sampled).
module intr_seq #(
  parameter int unsigned DRAIN_CYCLES = 3,
  parameter logic [7:0]  VEC_ADDR     = 8'h01
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       int_sig,
  input  logic       rti_in,
  input  logic [7:0] pc_in,
  input  logic       redirect_in,
  input  logic [7:0] redirect_pc_in,
  input  logic [7:0] mem_rdata_in,
  output logic       pc_write_en,
  output logic       if_id_write_en,
  output logic       flush_ifid,
  output logic       inject_bubble,
  output logic       memb_ovr,
  output logic [7:0] memb_addr,
  output logic       memb_we,
  output logic [7:0] memb_wdata,
  output logic       sp_sel,
  output logic       sp_dec,
  output logic       pc_ovr,
  output logic [7:0] pc_ovr_val,
  output logic       in_isr
);

  typedef enum logic [1:0] {IDLE, DRAIN, PUSH, VEC} state_t;

  localparam logic [2:0] CNT_LAST = 3'(DRAIN_CYCLES - 1);

  state_t     state;
  logic [2:0] cnt;
  logic       pending;
  logic [7:0] ret_pc;
  logic       start;

  assign start = (state == IDLE) && pending && !in_isr;

`ifdef INTR_SEQ_EDGE_EN
  logic int_prev;
  logic req_edge;
  assign req_edge = int_sig && !int_prev;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 3'd0;
      pending <= 1'b0;
      in_isr  <= 1'b0;
      ret_pc  <= 8'h00;
`ifdef INTR_SEQ_EDGE_EN
      int_prev <= 1'b0;
`endif
    end else begin
`ifdef INTR_SEQ_EDGE_EN
      int_prev <= int_sig;
      // A fresh edge wins over the clear so a request arriving on the accept cycle is not lost.
      if (req_edge)   pending <= 1'b1;
      else if (start) pending <= 1'b0;
`else
      if (start)                                      pending <= 1'b0;
      else if (state == IDLE && (!in_isr || rti_in)) pending <= int_sig;
`endif

      if (state == VEC) in_isr <= 1'b1;
      else if (rti_in)  in_isr <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            state  <= DRAIN;
            cnt    <= 3'd0;
            ret_pc <= pc_in;
          end
        end
        DRAIN: begin
          // Younger branches still resolve while draining; the last target is the true return point.
          if (redirect_in) ret_pc <= redirect_pc_in;
          if (cnt == CNT_LAST) begin
            state <= PUSH;
            cnt   <= 3'd0;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        PUSH:    state <= VEC;
        VEC:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default first so no path through the case can infer a latch.
  always_comb begin
    pc_write_en    = 1'b1;
    if_id_write_en = 1'b1;
    flush_ifid     = 1'b0;
    inject_bubble  = 1'b0;
    memb_ovr       = 1'b0;
    memb_addr      = 8'h00;
    memb_we        = 1'b0;
    memb_wdata     = 8'h00;
    sp_sel         = 1'b0;
    sp_dec         = 1'b0;
    pc_ovr         = 1'b0;
    pc_ovr_val     = 8'h00;
    case (state)
      IDLE: flush_ifid = start;
      DRAIN: begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        inject_bubble  = 1'b1;
      end
      PUSH: begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        memb_ovr       = 1'b1;
        memb_we        = 1'b1;
        memb_wdata     = ret_pc;
        sp_sel         = 1'b1;
        sp_dec         = 1'b1;
      end
      VEC: begin
        if_id_write_en = 1'b0;
        memb_ovr       = 1'b1;
        memb_addr      = VEC_ADDR;
        pc_ovr         = 1'b1;
        pc_ovr_val     = mem_rdata_in;
      end
      default: ;
    endcase
  end

endmodule
